string2_parser: RTL and testbench

- Byte-serial syntax checker for simple arithmetic expressions over ASCII characters.
- Grammar: expr := term (('+'|'*') term)*; term := digit | '(' expr ')'; digit is '0'..'9' (single digit per operand).
- Consumes one character per clock.
- Flags whether the prefix received since the last clear is a complete, well-formed expression.
- Sits after a character source such as a UART or stimulus ROM.

---
 rtl/string2_parser.sv | 83 ++++++++
 tb/tb_string2_parser.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/string2_parser.sv
// Byte-serial syntax checker for digit/'+'/'*'/paren expressions; out flags a complete valid prefix.
// Optional macro STRING2_SPACE_SKIP_EN: spaces are ignored outside the error state.
module string2_parser #(
  parameter int MAX_DEPTH = 15
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] in,
  output logic       out
);

  localparam int DW = (MAX_DEPTH < 1) ? 1 : $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);

  typedef enum logic [1:0] {
    S_EXPECT  = 2'd0,
    S_OPERAND = 2'd1,
    S_ERR     = 2'd2
  } state_t;

  state_t          state_q = S_EXPECT;
  state_t          state_d;
  logic [DW-1:0]   depth_q = '0;
  logic [DW-1:0]   depth_d;

  logic is_digit, is_lp, is_rp, is_op, skip;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_lp    = (in == 8'h28);
  assign is_rp    = (in == 8'h29);
  assign is_op    = (in == 8'h2B) || (in == 8'h2A);

`ifdef STRING2_SPACE_SKIP_EN
  assign skip = (in == 8'h20);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    // A skipped space holds everything; S_ERR holds regardless of input.
    if (!skip) begin
      case (state_q)
        S_EXPECT: begin
          if (is_digit) begin
            state_d = S_OPERAND;
          end else if (is_lp) begin
            if (depth_q < DMAX) depth_d = depth_q + DW'(1);
            else                state_d = S_ERR;
          end else begin
            state_d = S_ERR;
          end
        end
        S_OPERAND: begin
          if (is_op) begin
            state_d = S_EXPECT;
          end else if (is_rp) begin
            if (depth_q != '0) depth_d = depth_q - DW'(1);
            else               state_d = S_ERR;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_EXPECT;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
    end
  end

  assign out = (state_q == S_OPERAND) && (depth_q == '0);

endmodule

// File: tb/tb_string2_parser.sv
// Directed bench for string2_parser: a string-reduction model checked every cycle, plus literal expectations.
module tb_string2_parser;

  localparam int MAX_DEPTH = 15;
  localparam byte LP = 8'h28, RP = 8'h29, PL = 8'h2B, ST = 8'h2A, DG = 8'h64;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] in  = 8'h00;
  logic       out;

  int total = 0;
  int bad   = 0;

  string2_parser #(.MAX_DEPTH(MAX_DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .in  (in),
    .out (out)
  );

  always #5 clk = ~clk;

  // Model: the consumed characters since the last clear, judged as a whole string.
  byte hist[$];
  bit  model_on  = 1'b0;
  bit  model_exp = 1'b0;

  // Validity by rewriting: digits become 'd'; "(d)" and "d op d" collapse to 'd'.
  // A valid expression collapses to exactly one 'd' and never nests deeper than MAX_DEPTH.
  function automatic bit expr_ok(byte src[$]);
    byte w[$];
    int  lvl = 0;
    int  mx  = 0;
    bit  changed;
    foreach (src[i]) begin
      if (src[i] == LP) begin
        lvl++;
        if (lvl > mx) mx = lvl;
      end
      if (src[i] == RP) lvl--;
      if (src[i] >= 8'h30 && src[i] <= 8'h39) w.push_back(DG);
      else                                    w.push_back(src[i]);
    end
    if (mx > MAX_DEPTH) return 1'b0;
    changed = 1'b1;
    while (changed) begin
      changed = 1'b0;
      for (int i = 0; i + 2 < w.size(); i++) begin
        if ((w[i] == LP && w[i+1] == DG && w[i+2] == RP) ||
            (w[i] == DG && (w[i+1] == PL || w[i+1] == ST) && w[i+2] == DG)) begin
          w.delete(i + 2);
          w.delete(i + 1);
          w[i] = DG;
          changed = 1'b1;
          break;
        end
      end
    end
    return (w.size() == 1) && (w[0] == DG);
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      hist.delete();
      model_on = 1'b1;
    end else begin
`ifdef STRING2_SPACE_SKIP_EN
      if (in != 8'h20) hist.push_back(in);
`else
      hist.push_back(in);
`endif
    end
    model_exp = expr_ok(hist);
  end

  task automatic chk(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: out=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) chk("model", out, model_exp);
  end

  // One edge: drive at negedge, then check a literal expectation (<0 means none).
  task automatic step(input logic c, input byte ch, input int exp);
    @(negedge clk);
    clr = c;
    in  = ch;
    @(posedge clk);
    #1;
    if (exp >= 0) chk("literal", out, exp[0]);
  endtask

  task automatic run(input string s, input string e);
    for (int i = 0; i < s.len(); i++)
      step(1'b0, s[i], (e.len() == 0) ? -1 : int'(e[i]) - 48);
  endtask

  initial begin
    step(1'b1, 8'h00, 0);
    run("1+(1+2*1+2)*(3)", "100000000010001");

    step(1'b1, "7", 0);
    run("((7))", "00001");
    run("+", "0");
    run("5", "1");

    step(1'b1, 8'h00, 0);
    run(")", "0");
    run("1", "0");
    step(1'b1, 8'h00, 0);
    run("4", "1");

    step(1'b1, 8'h00, 0);
    run("12", "10");
    run("+3", "00");
    step(1'b1, 8'h00, 0);
    run("1-", "10");
    run("+2", "00");

    step(1'b1, 8'h00, 0);
    for (int i = 0; i < MAX_DEPTH; i++) step(1'b0, LP, 0);
    step(1'b0, "5", 0);
    for (int i = 0; i < MAX_DEPTH - 1; i++) step(1'b0, RP, 0);
    step(1'b0, RP, 1);

    step(1'b1, 8'h00, 0);
    for (int i = 0; i < MAX_DEPTH + 1; i++) step(1'b0, LP, 0);
    step(1'b0, "1", 0);
    for (int i = 0; i < MAX_DEPTH + 1; i++) step(1'b0, RP, 0);

    step(1'b1, 8'h00, 0);
    run("3*", "10");
    step(1'b1, "9", 0);
    run("9", "1");

    step(1'b1, 8'h00, 0);
`ifdef STRING2_SPACE_SKIP_EN
    run("1 + 2", "11001");
    step(1'b1, 8'h00, 0);
    run(" (3) ", "00011");
`else
    run("1 + 2", "10000");
    step(1'b1, 8'h00, 0);
    run(" (3) ", "00000");
`endif

    step(1'b1, 8'h00, 0);
    run("(1*2)+(3)", "000010001");
    step(1'b1, 8'h00, 0);
    run("((1)", "0000");
    step(1'b1, 8'h00, 0);
    run("1+)", "100");
    step(1'b1, 8'h00, 0);
    run("(+1)", "0000");
    step(1'b1, 8'h00, 0);
    run("8*(0+9)*((2))", "");

    step(1'b0, "+", -1);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
